// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared constants, AR-side state encoding and the outstanding-counter
// update helper for the instruction-fetch AXI read bridge.
package inst_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] INST_AXI_ID    = 4'd0;
  localparam logic [1:0] INST_SIZE_WORD = 2'b10;

  // AR_IDLE: free to accept a fetch; AR_WAIT: holding an AR request on the bus
  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_t;

  typedef logic [1:0] outst_t;

  // Up/down count of accepted-but-unanswered reads; a simultaneous
  // accept and completion leaves the count unchanged.
  function automatic outst_t outst_update(input outst_t cnt, input logic inc, input logic dec);
    outst_t res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 2'd1;
    end else if (!inc && dec) begin
      res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// Bundle of the fetch-side SRAM-like port and the AXI AR/R channels.
// 'master' is the bridge's view (it masters the AXI read bus and answers
// the fetch stage); 'slave' is the surrounding environment's view.
interface inst_axi_rd_bridge_if;

  // fetch-side SRAM-like port
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: turns SRAM-like req/addr_ok/data_ok fetches
// into single-beat AXI4 reads. Up to MAX_OUTST reads in flight with one
// fixed ARID, so responses come back in request order.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0] ARID_VAL  = INST_AXI_ID,
  parameter int         MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_axi_rd_bridge_if.master bus,
  output logic                 bridge_err
);

  localparam outst_t OUTST_LIMIT = outst_t'(MAX_OUTST);

  ar_state_t   r_state;
  ar_state_t   w_state_next;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  outst_t      r_outst;
  logic        r_data_ok;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_addr_ok;
  logic        w_ar_hs;
  logic        w_rready;
  logic        w_r_beat;
  logic        w_r_done;
  logic        w_wr_req;
  logic        w_resp_err;
  logic        w_unused;

  // handshake decodes
  assign w_ar_hs    = (r_state == AR_WAIT) & bus.arready;
  assign w_rready   = (r_outst != 2'd0);
  assign w_r_beat   = bus.rvalid & w_rready;
  assign w_r_done   = w_r_beat & bus.rlast;
  assign w_wr_req   = bus.inst_req & bus.inst_wr;
  assign w_resp_err = w_r_beat & (bus.rresp != AXI_RESP_OKAY);

  // write data and read ID carry no information for an in-order fetch path
  assign w_unused = ^{bus.inst_wdata, bus.rid};

  // fixed AR attributes: single-beat incrementing read
  assign bus.arid    = ARID_VAL;
  assign bus.arlen   = 8'd0;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;

  // arvalid is exactly "an accepted request has not yet been handed to AXI"
  assign bus.arvalid      = (r_state == AR_WAIT);
  assign bus.araddr       = r_araddr;
  assign bus.arsize       = r_arsize;
  assign bus.rready       = w_rready;
  assign bus.inst_addr_ok = w_addr_ok;
  assign bus.inst_data_ok = r_data_ok;
  assign bus.inst_rdata   = r_rdata;
  assign bridge_err       = r_err;

  // AR FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= AR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // AR FSM next state and fetch accept; writes are never accepted
  always_comb begin
    w_state_next = r_state;
    w_addr_ok    = 1'b0;
    case (r_state)
      AR_IDLE: begin
        w_addr_ok = bus.inst_req & ~bus.inst_wr & (r_outst < OUTST_LIMIT);
        if (w_addr_ok) begin
          w_state_next = AR_WAIT;
        end
      end
      AR_WAIT: begin
        if (w_ar_hs) begin
          w_state_next = AR_IDLE;
        end
      end
      default: w_state_next = AR_IDLE;
    endcase
  end

  // latch the AR payload at accept; it stays stable through AR_WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr <= 32'd0;
      r_arsize <= 3'd0;
    end else if (w_addr_ok) begin
      r_araddr <= bus.inst_addr;
      r_arsize <= {1'b0, bus.inst_size};
    end
  end

  // outstanding read counter: +1 per accept, -1 per completed R beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outst <= 2'd0;
    end else begin
      r_outst <= outst_update(r_outst, w_addr_ok, w_r_done);
    end
  end

  // one-cycle data_ok pulse after each completed beat; rdata holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_data_ok <= w_r_done;
      if (w_r_done) begin
        r_rdata <= bus.rdata;
      end
    end
  end

  // sticky error: write request presented or non-OKAY read response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_wr_req | w_resp_err) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: a fetch-stage driver and an in-order AXI
// read slave drive the bridge, while a transaction-level model (queue of
// accepted addresses, outstanding count, sticky error) predicts outputs.
module tb_inst_axi_rd_bridge;
  import inst_axi_rd_bridge_pkg::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  logic bridge_err;

  inst_axi_rd_bridge_if bus();

  inst_axi_rd_bridge #(.ARID_VAL(4'd0), .MAX_OUTST(MAXO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .bridge_err (bridge_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    int          gap;
  } freq_t;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } sbeat_t;

  // environment state
  freq_t  fq[$];
  sbeat_t sq[$];
  int gap_cnt      = 0;
  int r_delay      = 0;
  int ar_pct       = 100;
  int ar_stall     = 0;
  int err_beat_idx = -1;
  int n_rbeats     = 0;

  // reference model state
  logic [31:0] mq[$];
  int          m_outst = 0;
  bit          m_pend  = 0;
  logic [31:0] m_pend_addr = 32'd0;
  logic [2:0]  m_pend_size = 3'd0;
  bit          m_dok   = 0;
  logic [31:0] m_rdata = 32'd0;
  bit          m_err   = 0;

  // event timestamps (cycle numbers)
  int t_acc[$];
  int t_arhs[$];
  int t_rhs[$];
  int t_dok[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h9fc0_0000) return 32'h3c1a_0000;
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic clear_ts();
    t_acc.delete(); t_arhs.delete(); t_rhs.delete(); t_dok.delete();
  endtask

  task automatic drive_inputs();
    if (gap_cnt > 0) begin
      bus.inst_req = 1'b0;
      gap_cnt--;
    end else if (fq.size() > 0) begin
      bus.inst_req  = 1'b1;
      bus.inst_wr   = fq[0].wr;
      bus.inst_addr = fq[0].addr;
      bus.inst_size = fq[0].size;
    end else begin
      bus.inst_req = 1'b0;
      bus.inst_wr  = 1'b0;
    end
    bus.inst_wdata = $urandom;
    if (ar_stall > 0) bus.arready = 1'b0;
    else bus.arready = ($urandom_range(99) < ar_pct);
    bus.rid   = 4'd0;
    bus.rlast = 1'b1;
    if (sq.size() > 0 && cyc >= sq[0].rdy) begin
      bus.rvalid = 1'b1;
      bus.rdata  = mem_word(sq[0].addr);
      bus.rresp  = (n_rbeats == err_beat_idx) ? 2'b10 : 2'b00;
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      bus.rresp  = 2'b00;
    end
  endtask

  // one clock: check combinational outputs at negedge, advance model and
  // environment, then check registered outputs 1 time unit after posedge
  task automatic cycle();
    logic e_addr_ok, e_rready, e_r_hs;
    logic [22:0] e_fixed;
    @(negedge clk);
    if (reset) begin
      mq.delete(); sq.delete();
      m_outst = 0; m_pend = 0; m_dok = 0; m_rdata = 32'd0; m_err = 0;
    end else begin
      e_addr_ok = bus.inst_req & ~bus.inst_wr & ~m_pend & (m_outst < MAXO);
      e_rready  = (m_outst != 0);
      e_fixed   = {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0};
      total++;
      if (bus.inst_addr_ok !== e_addr_ok) begin
        bad++; $display("FAIL addr_ok cyc=%0d got=%b exp=%b", cyc, bus.inst_addr_ok, e_addr_ok);
      end
      total++;
      if (bus.rready !== e_rready) begin
        bad++; $display("FAIL rready cyc=%0d got=%b exp=%b", cyc, bus.rready, e_rready);
      end
      total++;
      if (bus.arvalid !== m_pend) begin
        bad++; $display("FAIL arvalid cyc=%0d got=%b exp=%b", cyc, bus.arvalid, m_pend);
      end
      total++;
      if ({bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot} !== e_fixed) begin
        bad++; $display("FAIL ar_fixed cyc=%0d got=%h exp=%h", cyc,
          {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot}, e_fixed);
      end
      if (m_pend) begin
        total++;
        if (bus.araddr !== m_pend_addr || bus.arsize !== m_pend_size) begin
          bad++; $display("FAIL ar_payload cyc=%0d got=%h/%0d exp=%h/%0d", cyc,
            bus.araddr, bus.arsize, m_pend_addr, m_pend_size);
        end
      end
      // environment reacts to the real bus
      if (bus.rvalid && bus.rready) begin
        if (sq.size() > 0) void'(sq.pop_front());
        n_rbeats++;
        t_rhs.push_back(cyc);
      end
      if (bus.arvalid && bus.arready) begin
        sq.push_back('{addr: bus.araddr, rdy: cyc + 1 + r_delay});
        t_arhs.push_back(cyc);
      end
      if (ar_stall > 0 && bus.arvalid) ar_stall--;
      if (bus.inst_addr_ok && fq.size() > 0) begin
        void'(fq.pop_front());
        gap_cnt = (fq.size() > 0) ? fq[0].gap : 0;
      end
      // model advances from its own predictions
      e_r_hs = bus.rvalid & e_rready;
      m_dok  = e_r_hs;
      if (e_r_hs && mq.size() > 0) begin
        m_rdata = mem_word(mq.pop_front());
        if (bus.rresp != 2'b00) m_err = 1;
      end
      if (bus.inst_req && bus.inst_wr) m_err = 1;
      if (m_pend && bus.arready) m_pend = 0;
      if (e_addr_ok) begin
        m_pend      = 1;
        m_pend_addr = bus.inst_addr;
        m_pend_size = {1'b0, bus.inst_size};
        mq.push_back(bus.inst_addr);
        t_acc.push_back(cyc);
      end
      m_outst = m_outst + int'(e_addr_ok) - int'(e_r_hs);
    end
    @(posedge clk);
    cyc++;
    #1;
    total++;
    if (bus.inst_data_ok !== m_dok) begin
      bad++; $display("FAIL data_ok cyc=%0d got=%b exp=%b", cyc, bus.inst_data_ok, m_dok);
    end
    if (bus.inst_data_ok === 1'b1) t_dok.push_back(cyc);
    total++;
    if (bus.inst_rdata !== m_rdata) begin
      bad++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, bus.inst_rdata, m_rdata);
    end
    total++;
    if (bridge_err !== m_err) begin
      bad++; $display("FAIL bridge_err cyc=%0d got=%b exp=%b", cyc, bridge_err, m_err);
    end
    drive_inputs();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((fq.size() > 0 || mq.size() > 0 || m_pend) && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (fq.size() > 0 || mq.size() > 0 || m_pend) begin
      bad++; $display("FAIL drain_timeout got=%0d_cycles exp=<%0d", n, budget);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic wr, input int gap);
    fq.push_back('{addr: a, size: INST_SIZE_WORD, wr: wr, gap: gap});
  endtask

  task automatic test_reset();
    do_reset(2);
    total++;
    if ({bus.arvalid, bus.rready, bus.inst_data_ok, bridge_err} !== 4'b0000 ||
        bus.araddr !== 32'd0 || bus.arsize !== 3'd0 || bus.inst_rdata !== 32'd0) begin
      bad++; $display("FAIL reset_state got=%b/%h/%0d/%h exp=0000/0/0/0",
        {bus.arvalid, bus.rready, bus.inst_data_ok, bridge_err}, bus.araddr, bus.arsize, bus.inst_rdata);
    end
    // stray R beat with nothing outstanding must not be consumed
    sq.push_back('{addr: 32'h0, rdy: 0});
    repeat (3) cycle();
    total++;
    if (sq.size() != 1) begin
      bad++; $display("FAIL stray_beat got=%0d_left exp=1_left", sq.size());
    end
    sq.delete();
    cycle();
  endtask

  task automatic test_single_fetch();
    clear_ts(); ar_pct = 100; r_delay = 0; ar_stall = 0;
    push_req(32'h9fc0_0000, 1'b0, 0);
    cycle();
    wait_drain(50);
    total++;
    if (t_acc.size() != 1 || t_arhs.size() != 1 || t_dok.size() != 1) begin
      bad++; $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/1", t_acc.size(), t_arhs.size(), t_dok.size());
    end else begin
      total++;
      if (t_arhs[0] - t_acc[0] != 1) begin
        bad++; $display("FAIL single_ar_lat got=%0d exp=1", t_arhs[0] - t_acc[0]);
      end
      total++;
      if (t_dok[0] - t_acc[0] != 3) begin
        bad++; $display("FAIL single_dok_lat got=%0d exp=3", t_dok[0] - t_acc[0]);
      end
    end
    total++;
    if (bus.inst_rdata !== 32'h3c1a_0000) begin
      bad++; $display("FAIL single_rdata got=%h exp=3c1a0000", bus.inst_rdata);
    end
    $display("single fetch: acc=%0d dok=%0d", t_acc.size(), t_dok.size());
  endtask

  task automatic test_arready_stall();
    clear_ts(); ar_pct = 100; r_delay = 0; ar_stall = 5;
    push_req(32'h0000_1000, 1'b0, 0);
    push_req(32'h0000_1004, 1'b0, 0);
    cycle();
    wait_drain(80);
    total++;
    if (t_acc.size() != 2 || t_arhs.size() != 2 || t_dok.size() != 2) begin
      bad++; $display("FAIL stall_counts got=%0d/%0d/%0d exp=2/2/2", t_acc.size(), t_arhs.size(), t_dok.size());
    end else begin
      total++;
      if (t_arhs[0] - t_acc[0] != 6) begin
        bad++; $display("FAIL stall_ar_lat got=%0d exp=6", t_arhs[0] - t_acc[0]);
      end
      total++;
      if (t_acc[1] != t_arhs[0] + 1) begin
        bad++; $display("FAIL stall_next_acc got=%0d exp=%0d", t_acc[1], t_arhs[0] + 1);
      end
    end
    $display("arready stall: acc=%0d dok=%0d", t_acc.size(), t_dok.size());
  endtask

  task automatic test_full();
    clear_ts(); ar_pct = 100; r_delay = 10; ar_stall = 0;
    push_req(32'h0000_2000, 1'b0, 0);
    push_req(32'h0000_2004, 1'b0, 0);
    push_req(32'h0000_2008, 1'b0, 0);
    cycle();
    wait_drain(120);
    total++;
    if (t_acc.size() != 3 || t_rhs.size() != 3 || t_dok.size() != 3) begin
      bad++; $display("FAIL full_counts got=%0d/%0d/%0d exp=3/3/3", t_acc.size(), t_rhs.size(), t_dok.size());
    end else begin
      total++;
      if (t_acc[1] - t_acc[0] != 2) begin
        bad++; $display("FAIL full_second_acc got=%0d exp=2", t_acc[1] - t_acc[0]);
      end
      total++;
      if (t_acc[2] != t_rhs[0] + 1) begin
        bad++; $display("FAIL full_third_acc got=%0d exp=%0d", t_acc[2], t_rhs[0] + 1);
      end
    end
    r_delay = 0;
    $display("full: acc=%0d dok=%0d", t_acc.size(), t_dok.size());
  endtask

  task automatic test_same_cycle();
    clear_ts(); ar_pct = 100; r_delay = 0; ar_stall = 0;
    push_req(32'h0000_3000, 1'b0, 0);
    push_req(32'h0000_3004, 1'b0, 0);
    cycle();
    wait_drain(60);
    total++;
    if (t_acc.size() != 2 || t_rhs.size() != 2 || t_dok.size() != 2) begin
      bad++; $display("FAIL same_counts got=%0d/%0d/%0d exp=2/2/2", t_acc.size(), t_rhs.size(), t_dok.size());
    end else begin
      total++;
      if (t_acc[1] != t_rhs[0]) begin
        bad++; $display("FAIL same_cycle_acc got=%0d exp=%0d", t_acc[1], t_rhs[0]);
      end
    end
    $display("same cycle: acc=%0d dok=%0d", t_acc.size(), t_dok.size());
  endtask

  task automatic test_rresp_err();
    clear_ts(); ar_pct = 100; r_delay = 1; ar_stall = 0;
    err_beat_idx = n_rbeats + 1;
    push_req(32'h0000_4000, 1'b0, 0);
    push_req(32'h0000_4004, 1'b0, 0);
    push_req(32'h0000_4008, 1'b0, 1);
    cycle();
    wait_drain(80);
    repeat (3) cycle();
    err_beat_idx = -1;
    total++;
    if (bridge_err !== 1'b1 || t_dok.size() != 3) begin
      bad++; $display("FAIL rresp_err got=%b/%0d exp=1/3", bridge_err, t_dok.size());
    end
    do_reset(1);
    total++;
    if (bridge_err !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%b exp=0", bridge_err);
    end
    $display("rresp error: dok=%0d", t_dok.size());
  endtask

  task automatic test_write_err();
    clear_ts();
    push_req(32'h0000_5000, 1'b1, 0);
    repeat (5) cycle();
    total++;
    if (bridge_err !== 1'b1 || t_acc.size() != 0) begin
      bad++; $display("FAIL write_err got=%b/%0d exp=1/0", bridge_err, t_acc.size());
    end
    fq.delete();
    do_reset(1);
    cycle();
    $display("write request: acc=%0d", t_acc.size());
  endtask

  task automatic test_reset_mid();
    int n;
    ar_pct = 100; r_delay = 10; ar_stall = 0;
    push_req(32'h0000_6000, 1'b0, 0);
    push_req(32'h0000_6004, 1'b0, 0);
    push_req(32'h0000_6008, 1'b0, 0);
    clear_ts();
    n = 0;
    while (t_arhs.size() < 1 && n < 20) begin cycle(); n++; end
    ar_stall = 20;
    while (t_acc.size() < 2 && n < 40) begin cycle(); n++; end
    cycle();
    total++;
    if (m_outst != 2 || !m_pend) begin
      bad++; $display("FAIL reset_mid_setup got=%0d/%0d exp=2/1", m_outst, m_pend);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ar_stall = 0;
    clear_ts();
    #1;
    total++;
    if ({bus.arvalid, bus.rready, bus.inst_data_ok, bus.inst_addr_ok} !== {3'b000, bus.inst_req}) begin
      bad++; $display("FAIL reset_mid got=%b exp=000%b",
        {bus.arvalid, bus.rready, bus.inst_data_ok, bus.inst_addr_ok}, bus.inst_req);
    end
    wait_drain(80);
    total++;
    if (t_dok.size() != 1) begin
      bad++; $display("FAIL reset_mid_dok got=%0d exp=1", t_dok.size());
    end
    r_delay = 0;
    $display("reset mid-transaction: dok=%0d", t_dok.size());
  endtask

  task automatic test_random();
    int n;
    clear_ts(); ar_pct = 60; ar_stall = 0;
    for (int i = 0; i < 200; i++) begin
      fq.push_back('{addr: {$urandom_range(32'h3fff_ffff), 2'b00},
                     size: 2'($urandom_range(2)), wr: 1'b0, gap: $urandom_range(3)});
    end
    n = 0;
    while ((fq.size() > 0 || mq.size() > 0 || m_pend) && n < 4000) begin
      r_delay = $urandom_range(6);
      cycle();
      n++;
    end
    total++;
    if (t_acc.size() != 200 || t_dok.size() != 200) begin
      bad++; $display("FAIL random_counts got=%0d/%0d exp=200/200", t_acc.size(), t_dok.size());
    end
    ar_pct = 100; r_delay = 0;
    $display("random: acc=%0d dok=%0d cycles=%0d", t_acc.size(), t_dok.size(), n);
  endtask

  initial begin
    reset          = 1'b1;
    bus.inst_req   = 1'b0;
    bus.inst_wr    = 1'b0;
    bus.inst_size  = INST_SIZE_WORD;
    bus.inst_addr  = 32'd0;
    bus.inst_wdata = 32'd0;
    bus.arready    = 1'b0;
    bus.rid        = 4'd0;
    bus.rdata      = 32'd0;
    bus.rresp      = 2'b00;
    bus.rlast      = 1'b1;
    bus.rvalid     = 1'b0;
    test_reset();
    test_single_fetch();
    test_arready_stall();
    test_full();
    test_same_cycle();
    test_rresp_err();
    test_write_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
